// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int bit_cycles(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-two byte FIFO holding key bytes until the serializer takes them.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [DATA_BITS-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic                 w_push;
  logic                 w_pop;

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the
  // pointers, so stale entries are never presented as valid data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates key and status bytes onto one UART line with CTS flow control.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 instead of 8N1).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 key_valid,
  input  logic [DATA_BITS-1:0] key_data,
  input  logic                 stat_valid,
  input  logic [DATA_BITS-1:0] stat_data,
  output logic                 stat_ready,
  input  logic                 uart_cts_n,
  output logic                 UART_TXD,
  output logic                 tx_busy,
  output logic [7:0]           drop_count
);

  localparam int BIT_CYC = bit_cycles(CLK_HZ, BAUD_RATE);
  localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYC - 1);

  tx_state_e            r_state;
  logic [TW-1:0]        r_timer;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_prio_key;
  logic [7:0]           r_drop_cnt;
  logic                 r_cts_meta;
  logic                 r_cts_sync;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic                 w_cts_ok;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_head;
  logic                 w_can_grant;
  logic                 w_grant_key;
  logic                 w_grant_stat;
  logic [DATA_BITS-1:0] w_tx_byte;
  logic                 w_push;
  logic                 w_drop;

  // NOTE: the two synchronizer flops feed each other directly; any logic
  // between them would defeat metastability settling.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= uart_cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = ~r_cts_sync;

  // Round-robin: r_prio_key breaks ties, and flips to the other source on each grant.
  assign w_can_grant  = (r_state == IDLE) && w_cts_ok;
  assign w_grant_key  = w_can_grant && !w_fifo_empty && (!stat_valid || r_prio_key);
  assign w_grant_stat = w_can_grant && stat_valid && (w_fifo_empty || !r_prio_key);
  assign w_tx_byte    = w_grant_key ? w_fifo_head : stat_data;
  assign stat_ready   = w_grant_stat;

  assign w_push = key_valid && (!w_fifo_full || w_grant_key);
  assign w_drop = key_valid && !w_push;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_pop   (w_grant_key),
    .i_data  (key_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_timer    <= BIT_LAST;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_prio_key <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_grant_key || w_grant_stat) begin
            r_shift    <= w_tx_byte;
            r_prio_key <= w_grant_stat;
            r_state    <= START;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
            r_timer    <= BIT_LAST;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^w_tx_byte;
`endif
          end
        end
        START: begin
          if (r_timer == '0) begin
            r_state   <= DATA;
            r_timer   <= BIT_LAST;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        DATA: begin
          if (r_timer == '0) begin
            r_timer <= BIT_LAST;
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_parity;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (r_timer == '0) begin
            r_state <= STOP;
            r_timer <= BIT_LAST;
            r_txd   <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_timer == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_txd   <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign UART_TXD   = r_txd;
  assign tx_busy    = r_busy;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler at default parameters.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx_scheduler;

  localparam int BIT = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_data;
  logic       stat_valid;
  logic [7:0] stat_data;
  logic       cts_n;
  logic       stat_ready;
  logic       txd;
  logic       busy;
  logic [7:0] drop;

  int n_checks = 0;
  int n_errors = 0;
  int n_stat_rdy = 0;

  uart_tx_scheduler dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .stat_valid (stat_valid),
    .stat_data  (stat_data),
    .stat_ready (stat_ready),
    .uart_cts_n (cts_n),
    .UART_TXD   (txd),
    .tx_busy    (busy),
    .drop_count (drop)
  );

  always #10 clk = ~clk;

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic cyc();
    @(negedge clk);
    if (stat_ready === 1'b1) n_stat_rdy++;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    stat_valid = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic push_key(input logic [7:0] d);
    key_valid = 1'b1;
    key_data  = d;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget, output int lat);
    lat = 0;
    while (txd !== 1'b0 && lat < budget) begin
      cyc();
      lat++;
    end
    check({tag, "_start_seen"}, txd, 1'b0);
  endtask

  // Entered on the first start-bit cycle; returns on the cycle after the frame.
  task automatic check_frame(input string tag, input logic [7:0] exp, input int cts_drop_at);
    logic [10:0] bits;
    int busy_cnt;
    bits     = '0;
    busy_cnt = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == cts_drop_at) cts_n = 1'b1;
      if (busy === 1'b1) busy_cnt++;
      if (k % BIT == BIT / 2) bits[k / BIT] = txd;
      cyc();
    end
    check({tag, "_startbit"}, bits[0], 1'b0);
    check({tag, "_data"}, bits[8:1], exp);
`ifdef UART_TX_PARITY_EN
    check({tag, "_parity"}, bits[9], ^exp);
    check({tag, "_stopbit"}, bits[10], 1'b1);
`else
    check({tag, "_stopbit"}, bits[9], 1'b1);
`endif
    check({tag, "_busy_len"}, busy_cnt, FRAME);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int lows;
    cts_n     = 1'b0;
    key_data  = '0;
    stat_data = '0;
    do_reset();
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_stat_ready", stat_ready, 1'b0);
    check("rst_drop", drop, 8'd0);

    // Single key: start bit two cycles after the strobe.
    push_key(8'h05);
    check("t1_grant_cycle_txd", txd, 1'b1);
    cyc();
    check("t1_start_txd", txd, 1'b0);
    check("t1_start_busy", busy, 1'b1);
    check_frame("t1", 8'h05, -1);

    // Contention: key first, status on the next grant.
    cts_n = 1'b1;
    do_reset();
    push_key(8'h01);
    stat_valid = 1'b1;
    stat_data  = 8'hA5;
    repeat (2) cyc();
    n_stat_rdy = 0;
    cts_n = 1'b0;
    wait_start("t2_key", 10, lat);
    check("t2_cts_latency", lat, 3);
    check_frame("t2_key", 8'h01, -1);
    check("t2_rdy_at_grant", stat_ready, 1'b1);
    cyc();
    stat_valid = 1'b0;
    check("t2_rdy_dropped", stat_ready, 1'b0);
    check("t2_stat_start", txd, 1'b0);
    check_frame("t2_stat", 8'hA5, -1);
    check("t2_rdy_pulses", n_stat_rdy, 1);

    // Overflow while not clear to send.
    cts_n = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push_key(8'h10 + 8'(i));
    cyc();
    check("t3_drop", drop, 8'd2);
    cts_n = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_start($sformatf("t3_f%0d", f), 10, lat);
      check($sformatf("t3_f%0d_gap", f), lat, (f == 0) ? 3 : 1);
      check_frame($sformatf("t3_f%0d", f), 8'h10 + 8'(f), -1);
    end
    lows = 0;
    repeat (200) begin
      cyc();
      if (txd !== 1'b1) lows++;
    end
    check("t3_no_fifth_frame", lows, 0);

    // CTS deasserted during data bit 3.
    push_key(8'h3C);
    push_key(8'hC3);
    wait_start("t4a", 10, lat);
    check_frame("t4a", 8'h3C, 4 * BIT + 100);
    lows = 0;
    repeat (20) begin
      cyc();
      if (txd !== 1'b1) lows++;
    end
    check("t4_held_by_cts", lows, 0);
    cts_n = 1'b0;
    wait_start("t4b", 10, lat);
    check("t4_cts_latency", lat, 3);
    check_frame("t4b", 8'hC3, -1);

    // Push on the grant cycle of a full FIFO, then reset mid-frame.
    cts_n = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) push_key(8'h20 + 8'(i));
    check("t5_drop_before", drop, 8'd2);
    cts_n = 1'b0;
    cyc();
    cyc();
    key_valid = 1'b1;
    key_data  = 8'h77;
    cyc();
    key_valid = 1'b0;
    check("t5_start", txd, 1'b0);
    check("t5_full_pop_push", drop, 8'd2);
    repeat (3 * BIT) cyc();
    rst_n = 1'b0;
    cyc();
    check("t5_rst_txd", txd, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_drop", drop, 8'd0);
    cyc();
    rst_n = 1'b1;
    lows = 0;
    repeat (300) begin
      cyc();
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_no_frame_after_reset", lows, 0);

    // Drop counter saturation.
    cts_n = 1'b1;
    do_reset();
    for (int i = 0; i < 264; i++) push_key(8'(i));
    check("t6_drop_saturates", drop, 8'd255);

    // Byte 0x07: odd popcount, so the even-parity bit is 1 when enabled.
    cts_n = 1'b0;
    do_reset();
    push_key(8'h07);
    wait_start("t7", 10, lat);
    check("t7_latency", lat, 1);
    check_frame("t7", 8'h07, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
